// File: rtl/zmips_wb_queue.sv
// Write-back queue in front of the zmips register file write port.
// In-order drain, one entry per cycle, with youngest-match read forwarding.
module zmips_wb_fwd #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic [DEPTH-1:0]             vld,   // index 0 is the oldest entry
  input  logic [DEPTH-1:0][4:0]        addr,
  input  logic [DEPTH-1:0][DATA_W-1:0] data,
  input  logic [4:0]                   rd_addr,
  output logic                         hit,
  output logic [DATA_W-1:0]            fwd_data
);
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    // Scanning oldest to youngest lets the last match win.
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && addr[i] == rd_addr && rd_addr != 5'd0 && rd_addr != 5'd31) begin
        hit      = 1'b1;
        fwd_data = data[i];
      end
    end
  end
endmodule

module zmips_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enq_valid,
  input  logic [4:0]                 enq_addr,
  input  logic [DATA_W-1:0]          enq_data,
  output logic                       enq_ready,
  input  logic                       drain_hold,
  output logic                       wr,
  output logic [4:0]                 wr_addr,
  output logic [DATA_W-1:0]          wr_data,
  input  logic [4:0]                 rd_addr_0,
  input  logic [4:0]                 rd_addr_1,
  output logic                       fwd_hit_0,
  output logic                       fwd_hit_1,
  output logic [DATA_W-1:0]          fwd_data_0,
  output logic [DATA_W-1:0]          fwd_data_1,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NUM_RD = 2;

  logic [DEPTH-1:0][4:0]        ent_addr;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;
  logic [DEPTH-1:0]             ent_vld;
  logic [PTR_W-1:0]             head, tail;
  logic                         push, pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign enq_ready = !full;
  // Writes to r0 and r31 finish the handshake but never occupy a slot.
  assign push      = enq_valid && enq_ready && enq_addr != 5'd0 && enq_addr != 5'd31;
  assign pop       = wr;

  assign wr      = !empty && !drain_hold;
  assign wr_addr = empty ? '0 : ent_addr[head];
  assign wr_data = empty ? '0 : ent_data[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      if (pop) begin
        ent_vld[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      if (push) begin
        ent_vld[tail] <= 1'b1;
        tail          <= tail + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset; validity is tracked by ent_vld and count.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= enq_addr;
      ent_data[tail] <= enq_data;
    end
  end

  logic [DEPTH-1:0]             ord_vld;
  logic [DEPTH-1:0][4:0]        ord_addr;
  logic [DEPTH-1:0][DATA_W-1:0] ord_data;

  for (genvar k = 0; k < DEPTH; k++) begin : g_rot
    assign ord_vld[k]  = ent_vld[head + PTR_W'(k)];
    assign ord_addr[k] = ent_addr[head + PTR_W'(k)];
    assign ord_data[k] = ent_data[head + PTR_W'(k)];
  end

  logic [NUM_RD-1:0][4:0]        rd_addr;
  logic [NUM_RD-1:0]             hit;
  logic [NUM_RD-1:0][DATA_W-1:0] fdata;

  assign rd_addr = {rd_addr_1, rd_addr_0};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_fwd
    zmips_wb_fwd #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fwd (
      .vld      (ord_vld),
      .addr     (ord_addr),
      .data     (ord_data),
      .rd_addr  (rd_addr[p]),
      .hit      (hit[p]),
      .fwd_data (fdata[p])
    );
  end

  assign fwd_hit_0  = hit[0];
  assign fwd_hit_1  = hit[1];
  assign fwd_data_0 = fdata[0];
  assign fwd_data_1 = fdata[1];
endmodule

// File: tb/tb_zmips_wb_queue.sv
// Directed bench for zmips_wb_queue; expected writes go to a scoreboard
// queue and a negedge monitor checks every register file write.
module tb_zmips_wb_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        enq_valid, enq_ready, drain_hold;
  logic [4:0]  enq_addr;
  logic [31:0] enq_data;
  logic        wr;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_0, rd_addr_1;
  logic        fwd_hit_0, fwd_hit_1;
  logic [31:0] fwd_data_0, fwd_data_1;
  logic [2:0]  count;
  logic        full, empty;

  typedef struct { logic [4:0] addr; logic [31:0] data; } exp_t;
  exp_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  zmips_wb_queue #(.DEPTH(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_addr(enq_addr), .enq_data(enq_data), .enq_ready(enq_ready),
    .drain_hold(drain_hold),
    .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1),
    .fwd_hit_0(fwd_hit_0), .fwd_hit_1(fwd_hit_1),
    .fwd_data_0(fwd_data_0), .fwd_data_1(fwd_data_1),
    .count(count), .full(full), .empty(empty)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at #1 after an edge; drives one enqueue across the next edge.
  task automatic enq(input logic [4:0] a, input logic [31:0] d, input bit stored);
    exp_t e;
    enq_valid = 1'b1;
    enq_addr  = a;
    enq_data  = d;
    if (stored) begin
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    enq_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && wr) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_wr: got addr %0d data %0h expected no write", wr_addr, wr_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", wr_data, e.data);
      end
    end
  end

  initial begin
    rst = 1'b1; enq_valid = 1'b0; enq_addr = '0; enq_data = '0;
    drain_hold = 1'b0; rd_addr_0 = '0; rd_addr_1 = '0;
    #2;
    chk("rst_wr", 32'(wr), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_enq_ready", 32'(enq_ready), 1);
    chk("rst_fwd", {30'd0, fwd_hit_1, fwd_hit_0}, 0);
    chk("rst_fwd_data", fwd_data_0 | fwd_data_1, 0);
    @(posedge clk); #1 rst = 1'b0;

    // single entry: presented one cycle after acceptance, then gone
    enq(5'd5, 32'h11111111, 1);
    chk("t1_wr", 32'(wr), 1);
    chk("t1_count", 32'(count), 1);
    @(posedge clk); #1;
    chk("t1_empty", 32'(empty), 1);
    chk("t1_wr_off", 32'(wr), 0);

    // fill under hold, reject fifth, drain back-to-back
    drain_hold = 1'b1;
    for (int i = 1; i <= 4; i++) enq(5'(i), 32'hA0 + 32'(i), 1);
    chk("t2_full", 32'(full), 1);
    chk("t2_count", 32'(count), 4);
    chk("t2_enq_ready", 32'(enq_ready), 0);
    chk("t2_wr_hold", 32'(wr), 0);
    enq(5'd6, 32'hA6, 0);
    chk("t2_count_rej", 32'(count), 4);
    drain_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_wr_consec", 32'(wr), 1);
    end
    @(posedge clk); #1;
    chk("t2_empty", 32'(empty), 1);

    // forwarding picks youngest, including while head is being written
    drain_hold = 1'b1;
    rd_addr_0  = 5'd7;
    enq(5'd7, 32'h100, 1);
    chk("t3_hit_a", 32'(fwd_hit_0), 1);
    chk("t3_data_a", fwd_data_0, 32'h100);
    enq(5'd7, 32'h200, 1);
    chk("t3_hit_b", 32'(fwd_hit_0), 1);
    chk("t3_data_b", fwd_data_0, 32'h200);
    drain_hold = 1'b0;
    @(negedge clk);
    chk("t3_wr", 32'(wr), 1);
    chk("t3_data_draining", fwd_data_0, 32'h200);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t3_hit_gone", 32'(fwd_hit_0), 0);
    chk("t3_data_gone", fwd_data_0, 0);

    // r0 and r31 handshake but are dropped
    rd_addr_1 = 5'd0;
    chk("t4_ready0", 32'(enq_ready), 1);
    enq(5'd0, 32'hDEAD0000, 0);
    chk("t4_count0", 32'(count), 0);
    chk("t4_ready31", 32'(enq_ready), 1);
    enq(5'd31, 32'hDEAD0031, 0);
    chk("t4_count31", 32'(count), 0);
    chk("t4_hit1_r0", 32'(fwd_hit_1), 0);
    rd_addr_1 = 5'd31;
    #1 chk("t4_hit1_r31", 32'(fwd_hit_1), 0);
    repeat (2) @(posedge clk);
    #1 chk("t4_empty", 32'(empty), 1);

    // steady push+pop at count 3, pointers wrap
    drain_hold = 1'b1;
    for (int i = 0; i < 3; i++) enq(5'd10 + 5'(i), 32'hB0 + 32'(i), 1);
    chk("t5_count_init", 32'(count), 3);
    drain_hold = 1'b0;
    for (int i = 0; i < 8; i++) begin
      enq(5'd13 + 5'(i), 32'hC0 + 32'(i), 1);
      chk("t5_count_steady", 32'(count), 3);
    end
    repeat (4) @(posedge clk);
    #1 chk("t5_empty", 32'(empty), 1);

    // async reset discards queued writes
    drain_hold = 1'b1;
    rd_addr_0  = 5'd8;
    enq(5'd8, 32'hE8, 1);
    enq(5'd9, 32'hE9, 1);
    chk("t6_count", 32'(count), 2);
    #2 rst = 1'b1;
    #1;
    chk("t6_wr", 32'(wr), 0);
    chk("t6_empty", 32'(empty), 1);
    chk("t6_count_rst", 32'(count), 0);
    chk("t6_hit", 32'(fwd_hit_0), 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    drain_hold = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("t6_empty_after", 32'(empty), 1);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
